fifo_drain_ctrl: RTL

Read-side sequencer for the async FIFO in the AHB-Lite/SPI bridge, on the FIFO read clock domain. On a start command it pops exactly burst_len words from the FIFO, absorbs the FIFO's one-cycle read latency in a 2-entry skid buffer, and presents the words on a valid/ready stream to the SPI framer. out_last marks the final word; done/err report completion.

---
 rtl/fifo_drain_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/fifo_drain_ctrl.sv
// Read-side burst sequencer for the bridge async FIFO with a 2-entry skid buffer.
// Define FIFO_DRAIN_TIMEOUT_EN to abort bursts starved for TIMEOUT_CYCLES cycles.
module fifo_drain_ctrl #(
    parameter int DATA_WIDTH     = 8,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  fifo_rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t                  state;
    logic [LEN_W-1:0]        issue_cnt;
    logic [LEN_W-1:0]        deliv_cnt;
    logic [DATA_WIDTH-1:0]   skid0;
    logic [DATA_WIDTH-1:0]   skid1;
    logic [1:0]              occ;
    logic                    inflight;
    logic                    pop;
    logic                    tmo;
    logic [2:0]              fill;

    assign pop       = out_valid & out_ready;
    assign fill      = {1'b0, occ} + {2'b00, inflight};
    assign out_valid = (occ != 2'd0);
    assign out_data  = skid0;
    assign out_last  = out_valid & (deliv_cnt == LEN_ONE);

    // Reads are limited so captured words can never overflow the skid.
    assign fifo_rd_en = !rst && (state == S_RUN) && (issue_cnt != '0)
                        && !fifo_empty && !tmo
                        && (fill < (3'd2 + {2'b00, pop}));

`ifdef FIFO_DRAIN_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SW-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || state != S_RUN) begin
            stall_cnt <= '0;
            tmo       <= 1'b0;
        end else if (fifo_rd_en) begin
            stall_cnt <= '0;
        end else if (issue_cnt != '0 && fifo_empty && !tmo) begin
            stall_cnt <= stall_cnt + SW'(1);
            if (stall_cnt == SW'(TIMEOUT_CYCLES - 1)) begin
                tmo <= 1'b1;
            end
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            deliv_cnt <= '0;
            skid0     <= '0;
            skid1     <= '0;
            occ       <= 2'd0;
            inflight  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= fifo_rd_en;
            if (fifo_rd_en) begin
                issue_cnt <= issue_cnt - LEN_ONE;
            end
            if (pop) begin
                deliv_cnt <= deliv_cnt - LEN_ONE;
            end

            // Capture lands at the tail; a pop shifts the head forward.
            unique case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        skid0 <= fifo_dout;
                    end else begin
                        skid1 <= fifo_dout;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= fifo_dout;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= fifo_dout;
                    end
                end
                default: ;
            endcase

            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (burst_len != '0) begin
                            issue_cnt <= burst_len;
                            deliv_cnt <= burst_len;
                            busy      <= 1'b1;
                            state     <= S_RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (pop && out_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (tmo && occ == 2'd0 && !inflight) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
